// File: rtl/sdram_local_arbiter.sv
// Round-robin arbiter sharing the DDR2 controller local port between two requesters.
// One single-beat command in flight; read data routed back to its owner through a tag FIFO.
module sdram_local_arbiter #(
    parameter int ADDR_W  = 23,
    parameter int DATA_W  = 32,
    parameter int BE_W    = 4,
    parameter int RD_TAGS = 8
) (
    input  logic                         phy_clk,
    input  logic                         reset_phy_clk_n,
    input  logic [1:0]                   rq_valid,
    input  logic [1:0]                   rq_write,
    input  logic [2*ADDR_W-1:0]          rq_addr,
    input  logic [2*DATA_W-1:0]          rq_wdata,
    input  logic [2*BE_W-1:0]            rq_be,
    output logic [1:0]                   rq_ready,
    output logic [DATA_W-1:0]            rq_rdata,
    output logic [1:0]                   rq_rdata_valid,
    input  logic                         local_init_done,
    input  logic                         local_ready,
    input  logic [DATA_W-1:0]            local_rdata,
    input  logic                         local_rdata_valid,
    output logic [ADDR_W-1:0]            local_address,
    output logic [DATA_W-1:0]            local_wdata,
    output logic [BE_W-1:0]              local_be,
    output logic [2:0]                   local_size,
    output logic                         local_burstbegin,
    output logic                         local_read_req,
    output logic                         local_write_req,
    output logic [$clog2(RD_TAGS):0]     rd_outstanding,
    output logic                         err_unexpected_rdata
);

    localparam int TAG_AW = $clog2(RD_TAGS);
    localparam int CNT_W  = TAG_AW + 1;
    localparam logic [CNT_W-1:0] TAGS_C = CNT_W'(RD_TAGS);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t             r_state;
    logic               r_rr_ptr;
    logic               r_owner;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [BE_W-1:0]    r_be;
    logic               r_bb;
    logic               r_rd_req;
    logic               r_wr_req;
    logic [CNT_W-1:0]   r_rd_cnt;
    logic [CNT_W-1:0]   r_wp;
    logic [CNT_W-1:0]   r_rp;
    logic               r_tag_mem [RD_TAGS];
    logic [DATA_W-1:0]  r_rq_rdata;
    logic [1:0]         r_rq_rdata_valid;
    logic               r_err;

    logic [1:0]         w_elig;
    logic               w_can_grant;
    logic               w_sel;
    logic               w_grant_rd;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_head_tag;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic [BE_W-1:0]    w_sel_be;

    always_comb begin
        w_elig[0]   = rq_valid[0] & (rq_write[0] | (r_rd_cnt < TAGS_C));
        w_elig[1]   = rq_valid[1] & (rq_write[1] | (r_rd_cnt < TAGS_C));
        w_can_grant = (r_state == S_IDLE) & local_init_done & (|w_elig);
        w_sel       = (&w_elig) ? r_rr_ptr : w_elig[1];
        w_grant_rd  = w_can_grant & ~rq_write[w_sel];
        rq_ready    = '0;
        if (w_can_grant)
            rq_ready[w_sel] = 1'b1;
        w_sel_addr  = w_sel ? rq_addr[2*ADDR_W-1:ADDR_W]  : rq_addr[ADDR_W-1:0];
        w_sel_wdata = w_sel ? rq_wdata[2*DATA_W-1:DATA_W] : rq_wdata[DATA_W-1:0];
        w_sel_be    = w_sel ? rq_be[2*BE_W-1:BE_W]        : rq_be[BE_W-1:0];
        w_empty     = (r_wp == r_rp);
        w_push      = (r_state == S_ISSUE) & local_ready & r_rd_req;
        w_pop       = local_rdata_valid & ~w_empty;
        w_head_tag  = r_tag_mem[r_rp[TAG_AW-1:0]];
    end

    always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
        if (!reset_phy_clk_n) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= 1'b0;
            r_owner  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_be     <= '0;
            r_bb     <= 1'b0;
            r_rd_req <= 1'b0;
            r_wr_req <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_can_grant) begin
                        r_owner  <= w_sel;
                        r_rr_ptr <= ~w_sel;
                        r_addr   <= w_sel_addr;
                        r_wdata  <= w_sel_wdata;
                        r_be     <= w_sel_be;
                        r_bb     <= 1'b1;
                        r_wr_req <= rq_write[w_sel];
                        r_rd_req <= ~rq_write[w_sel];
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_bb <= 1'b0;
                    if (local_ready) begin
                        r_wr_req <= 1'b0;
                        r_rd_req <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read slots are reserved at grant so the push on acceptance can never overflow.
    always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
        if (!reset_phy_clk_n) begin
            r_rd_cnt <= '0;
            r_wp     <= '0;
            r_rp     <= '0;
        end else begin
            case ({w_grant_rd, w_pop})
                2'b10:   r_rd_cnt <= r_rd_cnt + ONE_C;
                2'b01:   r_rd_cnt <= r_rd_cnt - ONE_C;
                default: r_rd_cnt <= r_rd_cnt;
            endcase
            if (w_push)
                r_wp <= r_wp + ONE_C;
            if (w_pop)
                r_rp <= r_rp + ONE_C;
        end
    end

    always_ff @(posedge phy_clk) begin
        if (w_push)
            r_tag_mem[r_wp[TAG_AW-1:0]] <= r_owner;
    end

    always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
        if (!reset_phy_clk_n) begin
            r_rq_rdata       <= '0;
            r_rq_rdata_valid <= '0;
            r_err            <= 1'b0;
        end else begin
            r_rq_rdata_valid <= '0;
            if (w_pop) begin
                r_rq_rdata                   <= local_rdata;
                r_rq_rdata_valid[w_head_tag] <= 1'b1;
            end
            if (local_rdata_valid & w_empty)
                r_err <= 1'b1;
        end
    end

    assign local_address        = r_addr;
    assign local_wdata          = r_wdata;
    assign local_be             = r_be;
    assign local_size           = 3'd1;
    assign local_burstbegin     = r_bb;
    assign local_read_req       = r_rd_req;
    assign local_write_req      = r_wr_req;
    assign rd_outstanding       = r_rd_cnt;
    assign rq_rdata             = r_rq_rdata;
    assign rq_rdata_valid       = r_rq_rdata_valid;
    assign err_unexpected_rdata = r_err;

endmodule
